// File: rtl/hi_low_game_ctrl.sv
// Hi-low / hot-cold game sequencer: turns the board buttons into commands, sequences
// seed load, guess counting and timed hints, and decides win or lose.
module hi_low_game_ctrl #(
    parameter int unsigned MAX_GUESSES = 6,
    parameter int unsigned HINT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rand_but_n,
    input  logic       hi_low_but_n,
    input  logic       hot_cold_but_n,
    input  logic       cmp_eq,
    input  logic       cmp_gt,
    input  logic       cmp_hot,
    input  logic       cmp_warm,
    output logic       rand_load,
    output logic       hint_valid,
    output logic       hint_sel,
    output logic [1:0] hint_code,
    output logic [3:0] guesses_left,
    output logic       win,
    output logic       lose,
    output logic [3:0] state_leds
);

    typedef enum logic [2:0] {StIdle, StSeed, StPlay, StHint, StDone} stateType;

    localparam logic [3:0] MaxGuess = 4'(MAX_GUESSES);
    localparam logic [7:0] HintLen  = 8'(HINT_CYCLES);

    // Button bits: [0] rand, [1] hi_low, [2] hot_cold; all stages idle high.
    logic [2:0] butSync1Q, butSync2Q, butPrevQ;
    logic [2:0] pressPulse;
    logic       randPress, hiLowPress, guessPress;

    stateType   stateQ, stateD;
    logic [7:0] hintCntQ, hintCntD;
    logic [3:0] guessesQ, guessesD;
    logic [3:0] stateLedsQ, stateLedsD;
    logic [1:0] hintCodeQ, hintCodeD, verdict;
    logic       randLoadQ, randLoadD;
    logic       hintValidQ, hintValidD;
    logic       hintSelQ, hintSelD;
    logic       winQ, winD, loseQ, loseD;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            butSync1Q <= 3'b111;
            butSync2Q <= 3'b111;
            butPrevQ  <= 3'b111;
        end else begin
            butSync1Q <= {hot_cold_but_n, hi_low_but_n, rand_but_n};
            butSync2Q <= butSync1Q;
            butPrevQ  <= butSync2Q;
        end
    end

    assign pressPulse = butPrevQ & ~butSync2Q;
    assign randPress  = pressPulse[0];
    assign hiLowPress = pressPulse[1];
    assign guessPress = pressPulse[1] | pressPulse[2];

    // hi_low wins over hot_cold when both guess buttons fire together.
    always_comb begin
        verdict = 2'b00;
        if (cmp_eq) begin
            verdict = 2'b11;
        end else if (hiLowPress) begin
            verdict = cmp_gt ? 2'b10 : 2'b01;
        end else if (cmp_hot) begin
            verdict = 2'b10;
        end else if (cmp_warm) begin
            verdict = 2'b01;
        end
    end

    always_comb begin
        stateD     = stateQ;
        randLoadD  = 1'b0;
        hintValidD = hintValidQ;
        hintSelD   = hintSelQ;
        hintCodeD  = hintCodeQ;
        guessesD   = guessesQ;
        winD       = winQ;
        loseD      = loseQ;
        hintCntD   = hintCntQ;
        unique case (stateQ)
            StIdle: begin
                if (randPress) begin
                    stateD    = StSeed;
                    randLoadD = 1'b1;
                end
            end
            StSeed: begin
                stateD     = StPlay;
                guessesD   = MaxGuess;
                winD       = 1'b0;
                loseD      = 1'b0;
                hintValidD = 1'b0;
            end
            StPlay: begin
                if (randPress) begin
                    stateD    = StSeed;
                    randLoadD = 1'b1;
                end else if (guessPress) begin
                    hintSelD   = ~hiLowPress;
                    hintCodeD  = verdict;
                    hintValidD = 1'b1;
                    if (cmp_eq) begin
                        stateD   = StDone;
                        winD     = 1'b1;
                        guessesD = guessesQ - 4'd1;
                    end else if (guessesQ <= 4'd1) begin
                        stateD   = StDone;
                        loseD    = 1'b1;
                        guessesD = 4'd0;
                    end else begin
                        stateD   = StHint;
                        guessesD = guessesQ - 4'd1;
                        hintCntD = HintLen;
                    end
                end
            end
            StHint: begin
                if (randPress) begin
                    stateD    = StSeed;
                    randLoadD = 1'b1;
                end else if (hintCntQ <= 8'd1) begin
                    stateD     = StPlay;
                    hintValidD = 1'b0;
                end else begin
                    hintCntD = hintCntQ - 8'd1;
                end
            end
            StDone: begin
                if (randPress) begin
                    stateD    = StSeed;
                    randLoadD = 1'b1;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        stateLedsD = 4'b1000;
        unique case (stateD)
            StIdle:         stateLedsD = 4'b0001;
            StSeed, StPlay: stateLedsD = 4'b0010;
            StHint:         stateLedsD = 4'b0100;
            default:        stateLedsD = 4'b1000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateQ     <= StIdle;
            randLoadQ  <= 1'b0;
            hintValidQ <= 1'b0;
            hintSelQ   <= 1'b0;
            hintCodeQ  <= 2'b00;
            guessesQ   <= 4'd0;
            winQ       <= 1'b0;
            loseQ      <= 1'b0;
            hintCntQ   <= 8'd0;
            stateLedsQ <= 4'b0001;
        end else begin
            stateQ     <= stateD;
            randLoadQ  <= randLoadD;
            hintValidQ <= hintValidD;
            hintSelQ   <= hintSelD;
            hintCodeQ  <= hintCodeD;
            guessesQ   <= guessesD;
            winQ       <= winD;
            loseQ      <= loseD;
            hintCntQ   <= hintCntD;
            stateLedsQ <= stateLedsD;
        end
    end

    assign rand_load    = randLoadQ;
    assign hint_valid   = hintValidQ;
    assign hint_sel     = hintSelQ;
    assign hint_code    = hintCodeQ;
    assign guesses_left = guessesQ;
    assign win          = winQ;
    assign lose         = loseQ;
    assign state_leds   = stateLedsQ;

endmodule

// File: tb/tb_hi_low_game_ctrl.sv
// Bench for hi_low_game_ctrl: directed game scenarios plus random button/comparator traffic,
// all checked every cycle against a game-level reference model.
module tb_hi_low_game_ctrl;

    localparam int MaxG  = 6;
    localparam int HintC = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rand_but_n = 1'b1, hi_low_but_n = 1'b1, hot_cold_but_n = 1'b1;
    logic       cmp_eq = 1'b0, cmp_gt = 1'b0, cmp_hot = 1'b0, cmp_warm = 1'b0;
    logic       rand_load, hint_valid, hint_sel, win, lose;
    logic [1:0] hint_code;
    logic [3:0] guesses_left, state_leds;

    int nCompared = 0;
    int nMismatched = 0;

    hi_low_game_ctrl #(
        .MAX_GUESSES(MaxG),
        .HINT_CYCLES(HintC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rand_but_n    (rand_but_n),
        .hi_low_but_n  (hi_low_but_n),
        .hot_cold_but_n(hot_cold_but_n),
        .cmp_eq        (cmp_eq),
        .cmp_gt        (cmp_gt),
        .cmp_hot       (cmp_hot),
        .cmp_warm      (cmp_warm),
        .rand_load     (rand_load),
        .hint_valid    (hint_valid),
        .hint_sel      (hint_sel),
        .hint_code     (hint_code),
        .guesses_left  (guesses_left),
        .win           (win),
        .lose          (lose),
        .state_leds    (state_leds)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: game phase, counters, and pin samples from the last three edges.
    typedef enum int {MIdle, MSeed, MPlay, MHint, MOver} phaseType;
    phaseType mPhase;
    int       mGuesses, mHintLeft, mCode;
    bit       mLoad, mHv, mSel, mWin, mLose;
    bit [2:0] pinAgo1, pinAgo2, pinAgo3, hit;

    function automatic int ledsFor(input phaseType p);
        case (p)
            MIdle:        return 1;
            MSeed, MPlay: return 2;
            MHint:        return 4;
            default:      return 8;
        endcase
    endfunction

    task automatic modelReset();
        mPhase = MIdle; mGuesses = 0; mHintLeft = 0; mCode = 0;
        mLoad = 0; mHv = 0; mSel = 0; mWin = 0; mLose = 0;
        pinAgo1 = '1; pinAgo2 = '1; pinAgo3 = '1;
    endtask

    task automatic modelStep();
        hit = pinAgo3 & ~pinAgo2;
        pinAgo3 = pinAgo2;
        pinAgo2 = pinAgo1;
        pinAgo1 = {hot_cold_but_n, hi_low_but_n, rand_but_n};
        mLoad = 0;
        if (hit[0] && mPhase != MSeed) begin
            mPhase = MSeed;
            mLoad = 1;
        end else begin
            case (mPhase)
                MSeed: begin
                    mPhase = MPlay; mGuesses = MaxG; mWin = 0; mLose = 0; mHv = 0;
                end
                MPlay: if (hit[1] || hit[2]) begin
                    mSel = !hit[1];
                    if (cmp_eq)        mCode = 3;
                    else if (!mSel)    mCode = cmp_gt ? 2 : 1;
                    else if (cmp_hot)  mCode = 2;
                    else if (cmp_warm) mCode = 1;
                    else               mCode = 0;
                    mHv = 1;
                    if (cmp_eq) begin
                        mPhase = MOver; mWin = 1; mGuesses = mGuesses - 1;
                    end else if (mGuesses == 1) begin
                        mPhase = MOver; mLose = 1; mGuesses = 0;
                    end else begin
                        mPhase = MHint; mGuesses = mGuesses - 1; mHintLeft = HintC;
                    end
                end
                MHint: begin
                    mHintLeft = mHintLeft - 1;
                    if (mHintLeft == 0) begin
                        mPhase = MPlay; mHv = 0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk);
            if (!reset_n) modelReset();
            else modelStep();
            #1;
            check("rand_load", rand_load, mLoad);
            check("hint_valid", hint_valid, mHv);
            check("hint_sel", hint_sel, mSel);
            check("hint_code", hint_code, mCode);
            check("guesses_left", guesses_left, mGuesses);
            check("win", win, mWin);
            check("lose", lose, mLose);
            check("state_leds", state_leds, ledsFor(mPhase));
        end
    end

    task automatic setPin(input int b, input logic v);
        case (b)
            0:       rand_but_n = v;
            1:       hi_low_but_n = v;
            default: hot_cold_but_n = v;
        endcase
    endtask

    task automatic pressBtn(input int b, input int hold);
        @(negedge clk);
        setPin(b, 1'b0);
        repeat (hold) @(negedge clk);
        setPin(b, 1'b1);
    endtask

    // Press, then report the edge count to the first rand_load and the number of pulses seen.
    task automatic pressAndWatch(input int b, input int hold, output int firstAt,
                                 output int count);
        firstAt = -1;
        count = 0;
        @(negedge clk);
        setPin(b, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (rand_load) begin
                count++;
                if (firstAt < 0) firstAt = i;
            end
            if (i == hold) begin
                @(negedge clk);
                setPin(b, 1'b1);
            end
        end
    endtask

    int loads, firstAt, hvCount;
    bit firstHv;

    initial begin
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_leds", state_leds, 1);
        check("reset_hint_valid", hint_valid, 0);
        reset_n = 1'b1;

        loads = 0;
        repeat (10) begin
            @(negedge clk);
            if (rand_load) loads++;
        end
        check("idle_no_load", loads, 0);
        check("idle_leds", state_leds, 1);
        check("idle_guesses", guesses_left, 0);

        pressAndWatch(0, 5, firstAt, loads);
        check("seed_latency", firstAt, 3);
        check("seed_pulse_count", loads, 1);
        check("seed_guesses", guesses_left, 6);
        check("seed_leds", state_leds, 2);

        cmp_gt = 1'b1;
        pressBtn(1, 1);
        hvCount = 0;
        firstHv = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) hot_cold_but_n = 1'b0;
            if (i == 1) hot_cold_but_n = 1'b1;
            if (hint_valid) begin
                hvCount++;
                if (firstHv) begin
                    check("hilow_code", hint_code, 2);
                    check("hilow_sel", hint_sel, 0);
                    firstHv = 0;
                end
            end
        end
        check("hint_cycles", hvCount, 4);
        check("hint_guesses", guesses_left, 5);
        check("hint_back_to_play", state_leds, 2);

        cmp_gt = 1'b0;
        cmp_warm = 1'b1;
        pressBtn(2, 1);
        repeat (2) @(negedge clk);
        check("warm_code", hint_code, 1);
        check("warm_sel", hint_sel, 1);
        check("warm_leds", state_leds, 4);
        repeat (6) @(negedge clk);
        cmp_hot = 1'b1;
        pressBtn(2, 1);
        repeat (2) @(negedge clk);
        check("hot_code", hint_code, 2);
        repeat (6) @(negedge clk);
        cmp_hot = 1'b0;
        cmp_warm = 1'b0;
        cmp_eq = 1'b1;
        pressBtn(2, 1);
        repeat (2) @(negedge clk);
        check("win_flag", win, 1);
        check("win_code", hint_code, 3);
        check("win_leds", state_leds, 8);
        check("win_guesses", guesses_left, 2);
        cmp_eq = 1'b0;
        pressBtn(1, 1);
        repeat (4) @(negedge clk);
        check("win_sticky", win, 1);
        check("win_sel_held", hint_sel, 1);
        check("win_guesses_frozen", guesses_left, 2);

        pressBtn(0, 1);
        repeat (4) @(negedge clk);
        check("restart_guesses", guesses_left, 6);
        check("restart_win_clear", win, 0);
        for (int g = 0; g < 6; g++) begin
            pressBtn(1, 1);
            repeat (8) @(negedge clk);
        end
        check("lose_flag", lose, 1);
        check("lose_guesses", guesses_left, 0);
        check("lose_leds", state_leds, 8);
        pressAndWatch(0, 1, firstAt, loads);
        check("lose_seed_latency", firstAt, 3);
        check("lose_restart_guesses", guesses_left, 6);
        check("lose_clear", lose, 0);

        @(negedge clk);
        rand_but_n = 1'b0;
        hi_low_but_n = 1'b0;
        @(negedge clk);
        rand_but_n = 1'b1;
        hi_low_but_n = 1'b1;
        repeat (5) @(negedge clk);
        check("coincide_guesses", guesses_left, 6);
        check("coincide_no_hint", hint_valid, 0);
        pressBtn(1, 1);
        repeat (3) @(negedge clk);
        check("pre_reset_hint", hint_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_hint_valid", hint_valid, 0);
        check("async_rst_guesses", guesses_left, 0);
        check("async_rst_leds", state_leds, 1);
        check("async_rst_code", hint_code, 0);
        check("async_rst_sel", hint_sel, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) rand_but_n = ~rand_but_n;
            if ($urandom_range(0, 4) == 0) hi_low_but_n = ~hi_low_but_n;
            if ($urandom_range(0, 4) == 0) hot_cold_but_n = ~hot_cold_but_n;
            cmp_eq   = ($urandom_range(0, 7) == 0);
            cmp_gt   = 1'($urandom_range(0, 1));
            cmp_hot  = 1'($urandom_range(0, 1));
            cmp_warm = 1'($urandom_range(0, 1));
            reset_n  = ($urandom_range(0, 999) != 0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        rand_but_n = 1'b1;
        hi_low_but_n = 1'b1;
        hot_cold_but_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
